hd_pair_deserializer: RTL and testbench



---
 rtl/hd_pair_deserializer_if.sv | 23 ++
 rtl/hd_pair_deserializer.sv | 129 ++++++++++++
 tb/tb_hd_pair_deserializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hd_pair_deserializer_if.sv
// Bundle of serial-input and pair-output signals for the Hamming pair deserializer.
// The slave modport is the deserializer; the master modport is its environment.
interface hd_pair_deserializer_if;
    logic       in_valid;
    logic       in_bit;
    logic       in_start;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] code_word1;
    logic [6:0] code_word2;
    logic       frame_err;
    logic       drop;

    modport master (
        output in_valid, in_bit, in_start, out_ready,
        input  out_valid, code_word1, code_word2, frame_err, drop
    );

    modport slave (
        input  in_valid, in_bit, in_start, out_ready,
        output out_valid, code_word1, code_word2, frame_err, drop
    );
endinterface

// File: rtl/hd_pair_deserializer.sv
// Serial-to-pair deserializer: collects 14-bit pairs of 7-bit Hamming codewords
// MSB first, buffers them in a small FIFO and presents the head under valid/ready.
// Framing restarts on in_start mid-pair; completed pairs that find the FIFO full
// are discarded and reported.
module hd_pair_deserializer #(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    hd_pair_deserializer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    cnt_r;
    logic [13:0]   shift_r;
    logic          frame_err_r;
    logic          drop_r;
    logic [13:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          restart_s;
    logic          complete_s;
    logic [13:0]   shift_next_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic [13:0]   head_s;

    // Decode framing events and FIFO push/pop qualifiers from registered state.
    always_comb begin
        restart_s    = 1'b0;
        complete_s   = 1'b0;
        shift_next_s = {shift_r[12:0], bus.in_bit};
        empty_s      = (count_r == {CW{1'b0}});
        full_s       = (count_r == CW'(DEPTH));
        pop_s        = 1'b0;
        push_s       = 1'b0;
        if (bus.in_valid) begin
            restart_s  = bus.in_start & (cnt_r != 4'd0);
            complete_s = ~restart_s & (cnt_r == 4'd13);
        end else begin
            restart_s  = 1'b0;
            complete_s = 1'b0;
        end
        if (!rst) begin
            pop_s  = ~empty_s & bus.out_ready;
            push_s = complete_s & (~full_s | pop_s);
        end else begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end
    end

    // Bit counter, shift register and framing-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 4'd0;
            shift_r     <= 14'd0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= restart_s;
            if (restart_s) begin
                // Partial pair abandoned; the current bit becomes bit 0.
                shift_r <= {13'd0, bus.in_bit};
                cnt_r   <= 4'd1;
            end else if (bus.in_valid) begin
                shift_r <= shift_next_s;
                cnt_r   <= (cnt_r == 4'd13) ? 4'd0 : (cnt_r + 4'd1);
            end else begin
                shift_r <= shift_r;
                cnt_r   <= cnt_r;
            end
        end
    end

    // FIFO pointers, occupancy and overflow-drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            drop_r   <= 1'b0;
        end else begin
            drop_r <= complete_s & full_s & ~pop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful where occupancy covers them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= shift_next_s;
        end
    end

    // Head entry, forced to zero when the FIFO is empty.
    always_comb begin
        head_s = 14'd0;
        if (!empty_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = 14'd0;
        end
    end

    assign bus.out_valid  = ~empty_s;
    assign bus.code_word1 = head_s[13:7];
    assign bus.code_word2 = head_s[6:0];
    assign bus.frame_err  = frame_err_r;
    assign bus.drop       = drop_r;
endmodule

// File: tb/tb_hd_pair_deserializer.sv
// Self-checking bench for hd_pair_deserializer: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_hd_pair_deserializer;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    hd_pair_deserializer_if bus ();

    hd_pair_deserializer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: bits of the pair being assembled, buffered pairs.
    bit         part_q[$];
    logic [13:0] fifo_q[$];
    logic        exp_fe;
    logic        exp_drop;

    task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic v, input logic b,
                                input logic s, input logic rdy);
        logic [6:0] cw1;
        logic [6:0] cw2;
        exp_fe   = 1'b0;
        exp_drop = 1'b0;
        if (r) begin
            part_q.delete();
            fifo_q.delete();
        end else begin
            if (rdy && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (v) begin
                if (s && part_q.size() != 0) begin
                    part_q.delete();
                    exp_fe = 1'b1;
                end
                part_q.push_back(b);
                if (part_q.size() == 14) begin
                    for (int k = 0; k < 7; k++) cw1[6-k] = part_q[k];
                    for (int k = 7; k < 14; k++) cw2[13-k] = part_q[k];
                    part_q.delete();
                    if (fifo_q.size() < DEPTH) fifo_q.push_back({cw1, cw2});
                    else exp_drop = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [13:0] head;
        head = (fifo_q.size() > 0) ? fifo_q[0] : 14'd0;
        check_val("out_valid",  {6'd0, bus.out_valid}, {6'd0, fifo_q.size() > 0});
        check_val("code_word1", bus.code_word1, head[13:7]);
        check_val("code_word2", bus.code_word2, head[6:0]);
        check_val("frame_err",  {6'd0, bus.frame_err}, {6'd0, exp_fe});
        check_val("drop",       {6'd0, bus.drop}, {6'd0, exp_drop});
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic cycle(input logic r, input logic v, input logic b,
                         input logic s, input logic rdy);
        rst          = r;
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.in_start = s;
        bus.out_ready = rdy;
        @(posedge clk);
        model_update(r, v, b, s, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_pair(input logic [13:0] p, input logic s0,
                             input logic rdy, input logic rdy_last);
        for (int k = 0; k < 14; k++)
            cycle(1'b0, 1'b1, p[13-k], (k == 0) ? s0 : 1'b0, (k == 13) ? rdy_last : rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        logic [13:0] pa;
        logic [13:0] pb;
        logic [13:0] pc;
        logic [13:0] p1;
        p1 = 14'b1010101_0101010;

        // Reset state.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Basic pair with out_ready high.
        send_pair(p1, 1'b1, 1'b1, 1'b1);
        check_val("tp1_valid", {6'd0, bus.out_valid}, 7'd1);
        check_val("tp1_cw1", bus.code_word1, 7'h55);
        check_val("tp1_cw2", bus.code_word2, 7'h2A);
        idle(1, 1'b1);
        check_val("tp1_empty", {6'd0, bus.out_valid}, 7'd0);

        // Same stream with in_valid low every other cycle.
        for (int k = 0; k < 14; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            cycle(1'b0, 1'b1, p1[13-k], 1'b0, 1'b1);
        end
        check_val("tp2_cw1", bus.code_word1, 7'h55);
        check_val("tp2_cw2", bus.code_word2, 7'h2A);
        idle(1, 1'b1);

        // Five bits, then a restarted fresh pair.
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        p1 = 14'b1111111_0000000;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check_val("tp3_frame_err", {6'd0, bus.frame_err}, 7'd1);
        for (int k = 1; k < 14; k++) cycle(1'b0, 1'b1, p1[13-k], 1'b0, 1'b1);
        check_val("tp3_cw1", bus.code_word1, 7'h7F);
        check_val("tp3_cw2", bus.code_word2, 7'h00);
        idle(2, 1'b1);

        // Overflow: three pairs with out_ready low.
        pa = 14'($urandom); pb = 14'($urandom); pc = 14'($urandom);
        send_pair(pa, 1'b0, 1'b0, 1'b0);
        send_pair(pb, 1'b0, 1'b0, 1'b0);
        send_pair(pc, 1'b0, 1'b0, 1'b0);
        check_val("tp4_drop", {6'd0, bus.drop}, 7'd1);
        check_val("tp4_head", bus.code_word1, pa[13:7]);
        idle(4, 1'b1);

        // Full FIFO popped in the cycle the third pair completes.
        pa = 14'($urandom); pb = 14'($urandom); pc = 14'($urandom);
        send_pair(pa, 1'b0, 1'b0, 1'b0);
        send_pair(pb, 1'b0, 1'b0, 1'b0);
        send_pair(pc, 1'b0, 1'b0, 1'b1);
        check_val("tp5_nodrop", {6'd0, bus.drop}, 7'd0);
        check_val("tp5_head", bus.code_word2, pb[6:0]);
        idle(4, 1'b1);

        // Reset mid-pair with one buffered entry.
        pa = 14'($urandom);
        send_pair(pa, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("tp6_rst_valid", {6'd0, bus.out_valid}, 7'd0);
        check_val("tp6_rst_cw1", bus.code_word1, 7'd0);
        pb = 14'($urandom);
        send_pair(pb, 1'b0, 1'b1, 1'b1);
        check_val("tp6_cw1", bus.code_word1, pb[13:7]);
        idle(2, 1'b1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  1'($urandom),
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 4) < 3) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
